ppu_vram_arbiter: RTL and testbench
===================================

// Module: ppu_vram_arbiter
// PURPOSE
//  Single-port owner of the PPU VRAM bus. Arbitrates single-beat accesses from three requesters:
//  background/sprite render fetch, palette colour loader, and CPU $2007 data port (reads and writes).
//  Replaces the static color_load_busy address mux; drives vram address, write data and write enable.
//  Returns read data with a per-requester valid strobe.
// PARAMETERS
//  READ_LAT      1    VRAM read latency in cycles, from address presented to data on vram_data_in (>=1)
//  CPU_MAX_WAIT  64   cycles a pending CPU request may lose arbitration before it is forced to top priority
// PORTS
//  clk            in   1   system clock; all state on posedge
//  rst            in   1   asynchronous, active-low reset
//  rnd_req        in   1   render fetch request; hold until rnd_gnt
//  rnd_addr       in   16  render fetch address
//  rnd_gnt        out  1   one-cycle grant pulse to render
//  rnd_rvalid     out  1   one-cycle pulse: rdata holds render read result
//  col_req        in   1   colour loader request; hold until col_gnt
//  col_addr       in   16  colour loader address
//  col_gnt        out  1   one-cycle grant pulse to colour loader
//  col_rvalid     out  1   one-cycle pulse: rdata holds colour read result
//  cpu_req        in   1   CPU port request; hold until cpu_gnt
//  cpu_we         in   1   1 = write, 0 = read (sampled with cpu_req)
//  cpu_addr       in   16  CPU port address
//  cpu_wdata      in   8   CPU write data
//  cpu_gnt        out  1   one-cycle grant pulse to CPU
//  cpu_rvalid     out  1   one-cycle pulse: rdata holds CPU read result (never for writes)
//  rdata          out  8   registered read data, shared by all requesters
//  vram_addr      out  16  VRAM address, = latched address & 16'h3FFF
//  vram_wdata     out  8   VRAM write data
//  vram_we        out  1   VRAM write enable
//  vram_data_in   in   8   VRAM read data
//  owner          out  2   current bus owner: 0 none, 1 render, 2 colour, 3 CPU
// BEHAVIOUR
//  Reset: state IDLE; all gnt/rvalid, vram_we, owner, rdata, vram_addr, vram_wdata, wait counter = 0.
//  Reset asserted mid-access aborts it: no rvalid is ever issued for the aborted beat.
//  States: IDLE, READ, WRITE.
//  IDLE: requests sampled only here. Winner chosen in cycle N; in N+1: its gnt=1 (one cycle),
//   owner set, address/we/wdata latched, vram_addr driven from latch. A req dropped before its
//   grant is ignored (no gnt). No request -> stay IDLE, owner=0.
//  Priority: cpu_wait >= CPU_MAX_WAIT -> CPU; else colour > render > CPU.
//  cpu_wait: 8-bit, +1 each IDLE-arbitration cycle cpu_req=1 and CPU loses (incl. cycles not in
//   IDLE while cpu_req=1); saturates at 255; cleared on cpu_gnt.
//  READ: stays READ_LAT+1 cycles (N+1 .. N+1+READ_LAT) with vram_addr stable; at end of N+1+READ_LAT
//   rdata <= vram_data_in. Cycle N+2+READ_LAT: state IDLE, matching xxx_rvalid=1 for one cycle,
//   owner=0, and IDLE arbitration runs in that same cycle -> next gnt earliest N+3+READ_LAT.
//   Read throughput: one beat per READ_LAT+2 cycles.
//  WRITE (CPU only): vram_we=1 and vram_wdata=cpu_wdata for exactly cycle N+1; IDLE at N+2.
//   No rvalid. Render/colour requests are always reads (no we input).
//  rdata holds its value until the next read completes; vram_we=0 outside WRITE.
//  Address: upper 2 bits masked off (14-bit PPU space, 0x4000 mirrors to 0x0000); no other decode.
//  At most one gnt and one rvalid asserted per cycle; gnt and rvalid may coincide only across
//   different beats (never in the same cycle, given the IDLE-arbitration latency above).
// TESTING
//  1 READ_LAT=1: rnd_req, rnd_addr=16'h2043 at N, mem[0x2043]=8'h5A -> rnd_gnt N+1, vram_addr=0x2043
//    N+1..N+2, rnd_rvalid N+3 with rdata=8'h5A, owner 1 then 0.
//  2 col_req and rnd_req both high at same cycle -> col_gnt first; rnd_gnt 3 cycles later; each
//    rvalid paired with its own data (0x3F00 -> palette byte, 0x0010 -> pattern byte).
//  3 cpu_req we=1 addr=16'h7F01 wdata=8'hA5 -> cpu_gnt N+1, vram_we=1 one cycle, vram_addr=0x3F01,
//    no cpu_rvalid; subsequent CPU read of 0x3F01 returns 8'hA5.
//  4 CPU_MAX_WAIT=4, rnd_req held high continuously, cpu_req read high -> cpu_gnt issued after
//    render beats once cpu_wait reaches 4; cpu_wait returns to 0 after grant.
//  5 rst low during READ (cycle N+1) -> all outputs 0 immediately; after release no rvalid for the
//    aborted beat; new request granted normally.
//  6 req pulsed one cycle while another beat in progress -> never granted, no rvalid.

Source files
------------

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: single owner of the PPU VRAM bus. It arbitrates single-beat accesses
// from three requesters: render fetch, palette colour loader and the CPU $2007 port.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   rnd_req/addr -> rnd_gnt       render fetch, read only; rnd_rvalid strobes its result
//   col_req/addr -> col_gnt       colour loader, read only; col_rvalid strobes its result
//   cpu_req/we/addr/wdata         CPU port, read or write; cpu_gnt, cpu_rvalid (reads only)
//   rdata                         registered read data shared by all requesters
//   vram_addr/wdata/we            VRAM bus; the address is masked to the 14-bit PPU space
//   vram_data_in                  VRAM read data, valid READ_LAT cycles after the address
//   owner                         0 none, 1 render, 2 colour, 3 CPU
module ppu_vram_arbiter #(
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned CPU_MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rnd_req,
  input  logic [15:0] rnd_addr,
  output logic        rnd_gnt,
  output logic        rnd_rvalid,
  input  logic        col_req,
  input  logic [15:0] col_addr,
  output logic        col_gnt,
  output logic        col_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  rdata,
  output logic [15:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_data_in,
  output logic [1:0]  owner
);

  localparam int unsigned CNT_W  = $clog2(READ_LAT + 1);
  localparam int unsigned WAIT_W = 8;
  localparam logic [15:0] ADDR_MASK = 16'h3FFF;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_RND  = 2'd1;
  localparam logic [1:0] OWN_COL  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   cpu_wait, cpu_wait_d;
  logic [1:0]          owner_d, win_c;
  logic                rnd_gnt_d, col_gnt_d, cpu_gnt_d;
  logic                rnd_rvalid_d, col_rvalid_d, cpu_rvalid_d;
  logic [7:0]          rdata_d, vram_wdata_d;
  logic [15:0]         vram_addr_d;
  logic                vram_we_d;
  logic                cpu_force_c;

  // A CPU request that has lost arbitration long enough overrides the fixed priority.
  assign cpu_force_c = (32'(cpu_wait) >= CPU_MAX_WAIT);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner;
    rnd_gnt_d    = 1'b0;
    col_gnt_d    = 1'b0;
    cpu_gnt_d    = 1'b0;
    rnd_rvalid_d = 1'b0;
    col_rvalid_d = 1'b0;
    cpu_rvalid_d = 1'b0;
    rdata_d      = rdata;
    vram_addr_d  = vram_addr;
    vram_wdata_d = vram_wdata;
    vram_we_d    = 1'b0;
    win_c        = OWN_NONE;

    case (state_q)
      IDLE: begin
        owner_d = OWN_NONE;
        if (cpu_req && cpu_force_c) win_c = OWN_CPU;
        else if (col_req)           win_c = OWN_COL;
        else if (rnd_req)           win_c = OWN_RND;
        else if (cpu_req)           win_c = OWN_CPU;

        cnt_d = '0;
        case (win_c)
          OWN_RND: begin
            rnd_gnt_d   = 1'b1;
            owner_d     = OWN_RND;
            vram_addr_d = rnd_addr & ADDR_MASK;
            state_d     = READ;
          end
          OWN_COL: begin
            col_gnt_d   = 1'b1;
            owner_d     = OWN_COL;
            vram_addr_d = col_addr & ADDR_MASK;
            state_d     = READ;
          end
          OWN_CPU: begin
            cpu_gnt_d   = 1'b1;
            owner_d     = OWN_CPU;
            vram_addr_d = cpu_addr & ADDR_MASK;
            if (cpu_we) begin
              vram_we_d    = 1'b1;
              vram_wdata_d = cpu_wdata;
              state_d      = WRITE;
            end else begin
              state_d = READ;
            end
          end
          default: ;
        endcase
      end

      // Hold the address READ_LAT+1 cycles, capture data on the last one.
      READ: begin
        if (cnt_q == CNT_W'(READ_LAT)) begin
          rdata_d = vram_data_in;
          state_d = IDLE;
          owner_d = OWN_NONE;
          case (owner)
            OWN_RND: rnd_rvalid_d = 1'b1;
            OWN_COL: col_rvalid_d = 1'b1;
            OWN_CPU: cpu_rvalid_d = 1'b1;
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WRITE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end

      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // CPU starvation counter: counts every cycle the CPU is left waiting.
    cpu_wait_d = cpu_wait;
    if (win_c == OWN_CPU || cpu_gnt) cpu_wait_d = '0;
    else if (cpu_req && cpu_wait != 8'hFF) cpu_wait_d = cpu_wait + 8'd1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cpu_wait   <= '0;
      owner      <= OWN_NONE;
      rnd_gnt    <= 1'b0;
      col_gnt    <= 1'b0;
      cpu_gnt    <= 1'b0;
      rnd_rvalid <= 1'b0;
      col_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      rdata      <= '0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      vram_we    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cpu_wait   <= cpu_wait_d;
      owner      <= owner_d;
      rnd_gnt    <= rnd_gnt_d;
      col_gnt    <= col_gnt_d;
      cpu_gnt    <= cpu_gnt_d;
      rnd_rvalid <= rnd_rvalid_d;
      col_rvalid <= col_rvalid_d;
      cpu_rvalid <= cpu_rvalid_d;
      rdata      <= rdata_d;
      vram_addr  <= vram_addr_d;
      vram_wdata <= vram_wdata_d;
      vram_we    <= vram_we_d;
    end
  end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// tb_ppu_vram_arbiter: directed stimulus for ppu_vram_arbiter with a VRAM model.
// The stimulus pushes expected grant and read-return events into queues, and a
// negedge monitor pops and compares them whenever the DUT strobes a gnt or rvalid.
module tb_ppu_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rnd_req = 1'b0, col_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] rnd_addr = '0, col_addr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        rnd_gnt, rnd_rvalid, col_gnt, col_rvalid, cpu_gnt, cpu_rvalid;
  logic [7:0]  rdata, vram_wdata;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_data_in = '0;
  logic [1:0]  owner;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  who;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } ev_t;

  ev_t gnt_q[$];
  ev_t rv_q[$];

  logic [7:0] mem [0:16383];

  ppu_vram_arbiter #(.READ_LAT(1), .CPU_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_gnt(rnd_gnt), .rnd_rvalid(rnd_rvalid),
    .col_req(col_req), .col_addr(col_addr), .col_gnt(col_gnt), .col_rvalid(col_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .rdata(rdata), .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_data_in(vram_data_in), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // VRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr[13:0]] <= vram_wdata;
    vram_data_in <= mem[vram_addr[13:0]];
  end

  // Monitor: compare every strobe against the next queued expectation.
  logic [1:0] who_g, who_r;
  always @(negedge clk) begin
    if (rst) begin
      vectors++;
      if ($countones({rnd_gnt, col_gnt, cpu_gnt}) > 1 ||
          $countones({rnd_rvalid, col_rvalid, cpu_rvalid}) > 1 ||
          (vram_we && !cpu_gnt)) begin
        miscompares++;
        $display("FAIL protocol cyc=%0d: gnt=%b rvalid=%b we=%b, required one-hot strobes and we only with cpu_gnt",
                 cyc, {cpu_gnt, col_gnt, rnd_gnt}, {cpu_rvalid, col_rvalid, rnd_rvalid}, vram_we);
      end

      if (rnd_gnt || col_gnt || cpu_gnt) begin
        who_g = cpu_gnt ? 2'd3 : (col_gnt ? 2'd2 : 2'd1);
        vectors++;
        if (gnt_q.size() == 0) begin
          miscompares++;
          $display("FAIL stray_gnt cyc=%0d: got gnt for requester %0d, required none", cyc, who_g);
        end else begin
          ev_t e;
          e = gnt_q.pop_front();
          if (e.cyc != cyc || e.who != who_g || owner != who_g ||
              vram_addr != e.addr || vram_we != e.we) begin
            miscompares++;
            $display("FAIL gnt: actual cyc=%0d who=%0d owner=%0d addr=%h we=%b, required cyc=%0d who=%0d owner=%0d addr=%h we=%b",
                     cyc, who_g, owner, vram_addr, vram_we, e.cyc, e.who, e.who, e.addr, e.we);
          end
        end
      end

      if (rnd_rvalid || col_rvalid || cpu_rvalid) begin
        who_r = cpu_rvalid ? 2'd3 : (col_rvalid ? 2'd2 : 2'd1);
        vectors++;
        if (rv_q.size() == 0) begin
          miscompares++;
          $display("FAIL stray_rvalid cyc=%0d: got rvalid for requester %0d data=%h, required none",
                   cyc, who_r, rdata);
        end else begin
          ev_t e;
          e = rv_q.pop_front();
          if (e.cyc != cyc || e.who != who_r || rdata != e.data || owner != 2'd0 ||
              vram_addr != e.addr) begin
            miscompares++;
            $display("FAIL rvalid: actual cyc=%0d who=%0d data=%h owner=%0d addr=%h, required cyc=%0d who=%0d data=%h owner=0 addr=%h",
                     cyc, who_r, rdata, owner, vram_addr, e.cyc, e.who, e.data, e.addr);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_gnt(input int c, input logic [1:0] who, input logic [15:0] addr, input logic we);
    ev_t e;
    e.cyc = c; e.who = who; e.addr = addr; e.we = we; e.data = 8'h00;
    gnt_q.push_back(e);
  endtask

  task automatic exp_rv(input int c, input logic [1:0] who, input logic [15:0] addr, input logic [7:0] d);
    ev_t e;
    e.cyc = c; e.who = who; e.addr = addr; e.we = 1'b0; e.data = d;
    rv_q.push_back(e);
  endtask

  task automatic check_all_zero(input string name);
    logic [40:0] act;
    act = {rnd_gnt, rnd_rvalid, col_gnt, col_rvalid, cpu_gnt, cpu_rvalid, vram_we,
           owner, rdata, vram_addr, vram_wdata};
    vectors++;
    if (act != 41'd0) begin
      miscompares++;
      $display("FAIL %s: outputs=%h, required all zero", name, act);
    end
  endtask

  int c;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2043] = 8'h5A;
    mem[14'h3F00] = 8'h1D;
    mem[14'h0010] = 8'h7E;

    // Reset state.
    step(2);
    check_all_zero("reset_state");
    rst = 1'b1;
    step(2);

    // 1: single render read.
    c = cyc;
    rnd_req = 1'b1; rnd_addr = 16'h2043;
    exp_gnt(c + 1, 2'd1, 16'h2043, 1'b0);
    exp_rv (c + 3, 2'd1, 16'h2043, 8'h5A);
    step(1); rnd_req = 1'b0;
    step(4);

    // 2: colour beats render when both request together.
    c = cyc;
    col_req = 1'b1; col_addr = 16'h3F00;
    rnd_req = 1'b1; rnd_addr = 16'h0010;
    exp_gnt(c + 1, 2'd2, 16'h3F00, 1'b0);
    exp_rv (c + 3, 2'd2, 16'h3F00, 8'h1D);
    exp_gnt(c + 4, 2'd1, 16'h0010, 1'b0);
    exp_rv (c + 6, 2'd1, 16'h0010, 8'h7E);
    step(1); col_req = 1'b0;
    step(3); rnd_req = 1'b0;
    step(4);

    // 3: CPU write to a mirrored address, then read it back.
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h7F01; cpu_wdata = 8'hA5;
    exp_gnt(c + 1, 2'd3, 16'h3F01, 1'b1);
    step(1); cpu_req = 1'b0; cpu_we = 1'b0;
    step(1);
    c = cyc;
    cpu_req = 1'b1; cpu_addr = 16'h3F01;
    exp_gnt(c + 1, 2'd3, 16'h3F01, 1'b0);
    exp_rv (c + 3, 2'd3, 16'h3F01, 8'hA5);
    step(1); cpu_req = 1'b0;
    step(4);

    // 4: starving CPU is forced ahead of continuous render traffic.
    c = cyc;
    rnd_req = 1'b1; rnd_addr = 16'h3F00;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2043;
    exp_gnt(c + 1,  2'd1, 16'h3F00, 1'b0);
    exp_rv (c + 3,  2'd1, 16'h3F00, 8'h1D);
    exp_gnt(c + 4,  2'd1, 16'h3F00, 1'b0);
    exp_rv (c + 6,  2'd1, 16'h3F00, 8'h1D);
    exp_gnt(c + 7,  2'd3, 16'h2043, 1'b0);
    exp_rv (c + 9,  2'd3, 16'h2043, 8'h5A);
    exp_gnt(c + 10, 2'd1, 16'h3F00, 1'b0);
    exp_rv (c + 12, 2'd1, 16'h3F00, 8'h1D);
    step(7);  cpu_req = 1'b0;
    step(3);  rnd_req = 1'b0;
    step(4);

    // 5: reset during a read aborts it; the next request proceeds normally.
    rnd_req = 1'b1; rnd_addr = 16'h2043;
    step(1);
    rst = 1'b0; rnd_req = 1'b0;
    #1;
    check_all_zero("reset_mid_read");
    step(2);
    rst = 1'b1;
    step(4);
    c = cyc;
    rnd_req = 1'b1; rnd_addr = 16'h0010;
    exp_gnt(c + 1, 2'd1, 16'h0010, 1'b0);
    exp_rv (c + 3, 2'd1, 16'h0010, 8'h7E);
    step(1); rnd_req = 1'b0;
    step(4);

    // 6: one-cycle pulses during a busy beat are never granted.
    c = cyc;
    rnd_req = 1'b1; rnd_addr = 16'h2043;
    exp_gnt(c + 1, 2'd1, 16'h2043, 1'b0);
    exp_rv (c + 3, 2'd1, 16'h2043, 8'h5A);
    step(1); rnd_req = 1'b0; col_req = 1'b1; col_addr = 16'h3F00;
    step(1); col_req = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0010;
    step(1); cpu_req = 1'b0;
    step(5);

    // Any expectation still queued was never delivered.
    while (gnt_q.size() > 0) begin
      ev_t e;
      e = gnt_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL missing_gnt: actual none, required who=%0d at cyc=%0d", e.who, e.cyc);
    end
    while (rv_q.size() > 0) begin
      ev_t e;
      e = rv_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL missing_rvalid: actual none, required who=%0d data=%h at cyc=%0d", e.who, e.data, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
